// File: rtl/rx_toe.sv
// rx_toe: channel-filtered command frame parser for the TOE receive stream.
// Optional idle-timeout abort: define RX_TOE_TIMEOUT_EN.
module rx_toe #(
    parameter logic [2:0]  CHAN    = 3'd0,
    parameter logic [7:0]  HDR0    = 8'h55,
    parameter logic [7:0]  HDR1    = 8'hAA,
    parameter logic [15:0] TIMEOUT = 16'd1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [7:0]  rx_data,
    input  logic [2:0]  rx_chan,
    output logic        rx_flag,
    output logic [7:0]  rx_type,
    output logic [15:0] rx_row,
    output logic [7:0]  rx_pic,
    output logic        err_pulse,
    output logic [7:0]  err_cnt,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR1, S_TYPE, S_ROWH, S_ROWL, S_PIC, S_CSUM
    } state_t;

    state_t      state, state_n;
    logic [7:0]  acc, acc_n;
    logic [7:0]  sh_type, sh_type_n;
    logic [15:0] sh_row, sh_row_n;
    logic [7:0]  sh_pic, sh_pic_n;
    logic        flag_n, err_n;
    logic        take;
    logic        to_hit;

    assign take = rx && (rx_chan == CHAN);
    assign busy = (state != S_IDLE);

`ifdef RX_TOE_TIMEOUT_EN
    logic [15:0] tcnt;

    always_ff @(posedge clk) begin
        if (!rst_n)
            tcnt <= 16'd0;
        else if (take || state == S_IDLE)
            tcnt <= 16'd0;
        else
            tcnt <= tcnt + 16'd1;
    end

    assign to_hit = (state != S_IDLE) && (tcnt == TIMEOUT);
`else
    logic unused_to;
    assign unused_to = ^TIMEOUT;
    assign to_hit    = 1'b0;
`endif

    always_comb begin
        state_n   = state;
        acc_n     = acc;
        sh_type_n = sh_type;
        sh_row_n  = sh_row;
        sh_pic_n  = sh_pic;
        flag_n    = 1'b0;
        err_n     = 1'b0;
        // a timeout wins over a byte landing in the same cycle
        if (to_hit) begin
            state_n = S_IDLE;
            err_n   = 1'b1;
        end else if (take) begin
            unique case (state)
                S_IDLE: begin
                    if (rx_data == HDR0)
                        state_n = S_HDR1;
                end
                S_HDR1: begin
                    if (rx_data == HDR1)
                        state_n = S_TYPE;
                    else if (rx_data != HDR0)
                        state_n = S_IDLE;
                end
                S_TYPE: begin
                    sh_type_n = rx_data;
                    acc_n     = rx_data;
                    state_n   = S_ROWH;
                end
                S_ROWH: begin
                    sh_row_n[15:8] = rx_data;
                    acc_n          = acc + rx_data;
                    state_n        = S_ROWL;
                end
                S_ROWL: begin
                    sh_row_n[7:0] = rx_data;
                    acc_n         = acc + rx_data;
                    state_n       = S_PIC;
                end
                S_PIC: begin
                    sh_pic_n = rx_data;
                    acc_n    = acc + rx_data;
                    state_n  = S_CSUM;
                end
                S_CSUM: begin
                    if (rx_data == acc)
                        flag_n = 1'b1;
                    else
                        err_n = 1'b1;
                    state_n = S_IDLE;
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            acc       <= 8'd0;
            sh_type   <= 8'd0;
            sh_row    <= 16'd0;
            sh_pic    <= 8'd0;
            rx_flag   <= 1'b0;
            err_pulse <= 1'b0;
            rx_type   <= 8'd0;
            rx_row    <= 16'd0;
            rx_pic    <= 8'd0;
            err_cnt   <= 8'd0;
        end else begin
            state     <= state_n;
            acc       <= acc_n;
            sh_type   <= sh_type_n;
            sh_row    <= sh_row_n;
            sh_pic    <= sh_pic_n;
            rx_flag   <= flag_n;
            err_pulse <= err_n;
            if (flag_n) begin
                rx_type <= sh_type;
                rx_row  <= sh_row;
                rx_pic  <= sh_pic;
            end
            if (err_n && err_cnt != 8'hFF)
                err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_rx_toe.sv
// tb_rx_toe: randomized + directed scoreboard bench for rx_toe.
// Build with RX_TOE_TIMEOUT_EN to exercise the timeout path (TIMEOUT=16).
module tb_rx_toe;

`ifdef RX_TOE_TIMEOUT_EN
    localparam logic [15:0] TO = 16'd16;
`else
    localparam logic [15:0] TO = 16'd1024;
`endif
    localparam logic [7:0] H0 = 8'h55;
    localparam logic [7:0] H1 = 8'hAA;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rx;
    logic [7:0]  rx_data;
    logic [2:0]  rx_chan;
    logic        rx_flag;
    logic [7:0]  rx_type;
    logic [15:0] rx_row;
    logic [7:0]  rx_pic;
    logic        err_pulse;
    logic [7:0]  err_cnt;
    logic        busy;

    rx_toe #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rx(rx), .rx_data(rx_data),
        .rx_chan(rx_chan), .rx_flag(rx_flag), .rx_type(rx_type),
        .rx_row(rx_row), .rx_pic(rx_pic), .err_pulse(err_pulse),
        .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          err;
        logic [7:0]  t;
        logic [15:0] r;
        logic [7:0]  p;
        logic [7:0]  ec;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] fb[$];
    logic [7:0] m_type, m_pic, m_ec;
    logic [15:0] m_row;
    int vecs = 0;
    int errs = 0;

    // reference model: collect candidate frame bytes, judge at 7 bytes
    task automatic push_ev(input bit e);
        ev_t v;
        v.err = e; v.t = m_type; v.r = m_row; v.p = m_pic; v.ec = m_ec;
        exp_q.push_back(v);
    endtask

    task automatic model_err();
        if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
        push_ev(1'b1);
    endtask

    task automatic model_byte(input logic [7:0] b);
        int s;
        fb.push_back(b);
        if (fb.size() == 1) begin
            if (b != H0) fb.delete();
        end else if (fb.size() == 2) begin
            if (b != H1) begin
                fb.delete();
                if (b == H0) fb.push_back(b);
            end
        end else if (fb.size() == 7) begin
            s = int'(fb[2]) + int'(fb[3]) + int'(fb[4]) + int'(fb[5]);
            if ((s % 256) == int'(fb[6])) begin
                m_type = fb[2];
                m_row  = {fb[3], fb[4]};
                m_pic  = fb[5];
                push_ev(1'b0);
            end else begin
                model_err();
            end
            fb.delete();
        end
    endtask

    task automatic send(input logic [7:0] b, input logic [2:0] ch);
        rx = 1'b1; rx_data = b; rx_chan = ch;
        if (ch == 3'd0) model_byte(b);
        @(posedge clk); #1;
        rx = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic frame(input logic [7:0] t, input logic [15:0] r,
                         input logic [7:0] p, input bit bad, input bit ilv);
        logic [7:0] f[7];
        f[0] = H0; f[1] = H1; f[2] = t; f[3] = r[15:8]; f[4] = r[7:0];
        f[5] = p;
        f[6] = t + r[15:8] + r[7:0] + p + (bad ? 8'd1 : 8'd0);
        for (int i = 0; i < 7; i++) begin
            send(f[i], 3'd0);
            if (ilv) send((i % 2) ? 8'h55 : 8'hFF, 3'd1);
            if (ilv && i == 4) idle(8);
        end
    endtask

    task automatic chk(input string nm, input int act, input int req);
        vecs++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin idle(1); n++; end
        vecs++;
        if (exp_q.size() != 0) begin
            errs++;
            $display("FAIL drain: %0d events outstanding, expected 0",
                     exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        fb.delete();
        m_type = 8'd0; m_row = 16'd0; m_pic = 8'd0; m_ec = 8'd0;
        idle(1);
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && (rx_flag || err_pulse)) begin
            vecs++;
            if (rx_flag && err_pulse) begin
                errs++;
                $display("FAIL both: rx_flag and err_pulse high together");
            end else if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL spurious: flag=%0b err=%0b with nothing expected",
                         rx_flag, err_pulse);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (e.err != err_pulse || rx_type != e.t || rx_row != e.r ||
                    rx_pic != e.p || err_cnt != e.ec) begin
                    errs++;
                    $display("FAIL event: got err=%0b t=%h r=%h p=%h ec=%h expected err=%0b t=%h r=%h p=%h ec=%h",
                             err_pulse, rx_type, rx_row, rx_pic, err_cnt,
                             e.err, e.t, e.r, e.p, e.ec);
                end
            end
        end
    end

    initial begin
        rx = 1'b0; rx_data = 8'd0; rx_chan = 3'd0;
        rst_n = 1'b0;
        m_type = 8'd0; m_row = 16'd0; m_pic = 8'd0; m_ec = 8'd0;
        idle(3);
        rst_n = 1'b1;
        chk("reset_flag", int'(rx_flag), 0);
        chk("reset_err", int'(err_pulse), 0);
        chk("reset_type", int'(rx_type), 0);
        chk("reset_row", int'(rx_row), 0);
        chk("reset_cnt", int'(err_cnt), 0);
        chk("reset_busy", int'(busy), 0);

        frame(8'h03, 16'h0120, 8'h07, 1'b0, 1'b0);
        idle(3);
        chk("t1_cnt", int'(err_cnt), 0);
        chk("t1_row", int'(rx_row), 'h0120);

        frame(8'h03, 16'h0120, 8'h07, 1'b1, 1'b0);
        idle(3);
        chk("t2_cnt", int'(err_cnt), 1);
        chk("t2_type", int'(rx_type), 'h03);
        chk("t2_pic", int'(rx_pic), 'h07);

        send(8'h55, 3'd0);
        frame(8'h10, 16'h0005, 8'h02, 1'b0, 1'b0);
        idle(3);
        chk("t3_type", int'(rx_type), 'h10);
        chk("t3_row", int'(rx_row), 'h0005);

        frame(8'h03, 16'h0120, 8'h07, 1'b0, 1'b1);
        idle(3);
        chk("t4_row", int'(rx_row), 'h0120);
        chk("t4_pic", int'(rx_pic), 'h07);

        send(H0, 3'd0); send(H1, 3'd0); send(8'h03, 3'd0);
`ifdef RX_TOE_TIMEOUT_EN
        fb.delete();
        model_err();
        idle(int'(TO) + 4);
        chk("t5_busy", int'(busy), 0);
        chk("t5_cnt", int'(err_cnt), 2);
        frame(8'h03, 16'h0120, 8'h07, 1'b0, 1'b0);
`else
        idle(40);
        chk("t5_busy", int'(busy), 1);
        send(8'h01, 3'd0); send(8'h20, 3'd0);
        send(8'h07, 3'd0); send(8'h2B, 3'd0);
`endif
        idle(3);
        drain();

        for (int k = 0; k < 200; k++) begin
            logic [15:0] r;
            r = 16'($urandom);
            if ($urandom_range(0, 7) == 0)
                send(8'($urandom_range(0, 255)), 3'd0);
            if ($urandom_range(0, 3) == 0)
                send(8'($urandom_range(0, 255)), 3'($urandom_range(1, 7)));
            frame(8'($urandom), r, 8'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0);
            idle($urandom_range(0, 3));
        end
        for (int i = 0; i < 7; i++) send(8'h00, 3'd0);
        idle(5);
        drain();

        send(H0, 3'd0); send(H1, 3'd0); send(8'h03, 3'd0); send(8'h01, 3'd0);
        do_reset();
        chk("t6_flag", int'(rx_flag), 0);
        chk("t6_type", int'(rx_type), 0);
        chk("t6_row", int'(rx_row), 0);
        chk("t6_pic", int'(rx_pic), 0);
        chk("t6_cnt", int'(err_cnt), 0);
        chk("t6_busy", int'(busy), 0);
        frame(8'h03, 16'h0120, 8'h07, 1'b0, 1'b0);
        idle(3);
        chk("t6_type2", int'(rx_type), 'h03);
        for (int i = 0; i < 300; i++)
            frame(8'($urandom), 16'($urandom), 8'($urandom), 1'b1, 1'b0);
        idle(3);
        chk("t6_sat", int'(err_cnt), 'hFF);
        chk("t6_hold", int'(rx_row), 'h0120);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/rx_toe.md
Name: rx_toe

Overview:
Receive-side parser for the TOE byte stream. It accepts bytes from the TOE receive interface and filters them by channel. It decodes fixed-format command frames (header, type, row, picture index, checksum) and presents each validated command as a one-cycle rx_flag with held fields. Its outputs feed the transmit-side controller's rx_flag/rx_type/rx_row/rx_pic inputs directly.

Parameters:
CHAN, 3'd0, TOE channel whose bytes are parsed; bytes on other channels are ignored.
HDR0, 8'h55, first header byte.
HDR1, 8'hAA, second header byte.
TIMEOUT, 16'd1024, max idle cycles between accepted bytes inside a frame (used only with RX_TOE_TIMEOUT_EN).

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst_n  input  1  reset, synchronous, active-low.
rx  input  1  byte strobe from TOE; rx_data/rx_chan valid when high.
rx_data  input  8  received byte.
rx_chan  input  3  channel of the received byte.
rx_flag  output  1  one-cycle pulse: a valid command frame was received.
rx_type  output  8  command type of the last valid frame.
rx_row  output  16  row number of the last valid frame, big-endian on the wire.
rx_pic  output  8  picture index of the last valid frame.
err_pulse  output  1  one-cycle pulse on checksum error or timeout abort.
err_cnt  output  8  saturating count of errors.
busy  output  1  high while a frame is partially received (state != S_IDLE).

Behaviour:
- Reset (rst_n low at a clock edge): state=S_IDLE; rx_flag=0, err_pulse=0, rx_type=0, rx_row=0, rx_pic=0, err_cnt=0, busy=0, checksum accumulator=0, timeout counter=0. Reset mid-frame discards the partial frame with no flag and no error.
- Accepted byte = rx high and rx_chan==CHAN. Bytes that are not accepted:
  - do not change state or the accumulator;
  - do not reset the timeout counter.
- Frame on wire: HDR0, HDR1, TYPE, ROW_H, ROW_L, PIC, CSUM. CSUM = (TYPE+ROW_H+ROW_L+PIC) mod 256.
- State transitions (on an accepted byte):
  - S_IDLE: byte==HDR0 -> S_HDR1; else stay.
  - S_HDR1: byte==HDR1 -> S_TYPE; byte==HDR0 -> stay in S_HDR1 (resync); else -> S_IDLE.
  - S_TYPE: latch type into shadow reg; acc=byte -> S_ROWH.
  - S_ROWH: shadow row[15:8]=byte; acc+=byte -> S_ROWL.
  - S_ROWL: shadow row[7:0]=byte; acc+=byte -> S_PIC.
  - S_PIC: shadow pic=byte; acc+=byte -> S_CSUM.
  - S_CSUM: byte==acc -> copy shadow regs to rx_type/rx_row/rx_pic and assert rx_flag; else assert err_pulse. Both cases -> S_IDLE.
  - Bytes inside a frame are never interpreted as header; no resync after S_HDR1.
- Latency: rx_flag and the updated fields appear at the output register on the edge after the CSUM byte is sampled, i.e. 1 cycle. rx_flag is high for exactly one cycle.
- Output fields hold their value until the next valid frame. Erroneous frames never modify rx_type/rx_row/rx_pic.
- err_cnt increments by 1 on every err_pulse and saturates at 8'hFF.
- Back-to-back frames: the HDR0 of the next frame may arrive on the cycle immediately after CSUM; no gap is required.
- rx_flag and err_pulse are never high in the same cycle.

Optional Feature:
- Macro RX_TOE_TIMEOUT_EN.
- Defined:
  - A 16-bit counter clears on every accepted byte and increments each cycle while state != S_IDLE.
  - When the count reaches TIMEOUT, the FSM returns to S_IDLE and asserts err_pulse for one cycle; err_cnt increments.
  - An accepted byte arriving in the same cycle as the timeout is discarded.
- Not defined: no counter; a partial frame waits indefinitely for its remaining bytes.

Test Plan:
1. Chan 0 bytes 55 AA 03 01 20 07 2B, consecutive cycles -> rx_flag pulses once, 1 cycle after 2B; rx_type=03, rx_row=0x0120, rx_pic=07; err_cnt=0.
2. Same frame with CSUM=2C -> no rx_flag, err_pulse once, err_cnt=1, fields unchanged from the prior frame.
3. Bytes 55 55 AA 10 00 05 02 17 -> resync; rx_flag, rx_type=10, rx_row=0x0005, rx_pic=02.
4. Frame of test 1 with chan-1 bytes FF/55 interleaved between every chan-0 byte, plus an 8-cycle rx gap after ROW_L -> rx_flag with values identical to test 1.
5. RX_TOE_TIMEOUT_EN, TIMEOUT=16: send 55 AA 03, then idle 16 cycles -> err_pulse, busy=0, err_cnt+1; a following full test-1 frame is accepted. Without the macro: same stimulus followed by 01 20 07 2B -> accepted.
6. rst_n low for 1 cycle after 55 AA 03 01 -> all outputs 0; the following test-1 frame is accepted; 300 bad-CSUM frames -> err_cnt=FF (saturated).
